// File: rtl/vctr_addr_sequencer.sv
// Address sequencer: pops address words from the address FIFO and issues
// vector-fetch requests, optionally expanding each word into an incrementing burst.
module vctr_addr_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int ADDR_INC = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_program,
  input  logic              end_program,
  input  logic              abort_program,
  input  logic              freeze_addr_fifo,
  input  logic              send_consec_addr,
  input  logic [7:0]        consec_count,
  input  logic [ADDR_W-1:0] addr_fifo_dout,
  input  logic              addr_fifo_empty,
  output logic              addr_fifo_rd,
  input  logic [15:0]       words_in_vctr_fifo,
  input  logic [15:0]       vector_fifo_threshold,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [2:0]        seq_state,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_aborted,
  output logic [CNT_W-1:0]  issued_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  seq_state_t state;
  logic [7:0] remaining;
  logic       pop_ok;

  assign pop_ok = !addr_fifo_empty && !freeze_addr_fifo &&
                  (words_in_vctr_fifo < vector_fifo_threshold);

  // The pop strobe is decided in FETCH itself so the FIFO data is valid in LOAD.
  assign addr_fifo_rd = reset && (state == ST_FETCH) && !abort_program && pop_ok;
  assign seq_state    = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      req_valid   <= 1'b0;
      req_addr    <= '0;
      remaining   <= '0;
      issued_cnt  <= '0;
      seq_done    <= 1'b0;
      seq_aborted <= 1'b0;
      seq_busy    <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run_program && !abort_program) begin
            state       <= ST_FETCH;
            seq_busy    <= 1'b1;
            issued_cnt  <= '0;
            seq_aborted <= 1'b0;
          end
        end

        ST_FETCH: begin
          if (abort_program) begin
            state       <= ST_DONE;
            seq_busy    <= 1'b0;
            seq_done    <= 1'b1;
            seq_aborted <= 1'b1;
          end else if (addr_fifo_empty && end_program) begin
            state    <= ST_DONE;
            seq_busy <= 1'b0;
            seq_done <= 1'b1;
          end else if (addr_fifo_rd) begin
            state <= ST_LOAD;
          end
        end

        // Abort is not checked here so the word just popped is always offered.
        ST_LOAD: begin
          req_addr  <= addr_fifo_dout;
          remaining <= send_consec_addr ? consec_count : 8'd0;
          req_valid <= 1'b1;
          state     <= ST_ISSUE;
        end

        ST_ISSUE: begin
          if (req_ready) begin
            issued_cnt <= issued_cnt + CNT_W'(1);
          end
          if (abort_program) begin
            state       <= ST_DONE;
            req_valid   <= 1'b0;
            seq_busy    <= 1'b0;
            seq_done    <= 1'b1;
            seq_aborted <= 1'b1;
          end else if (req_ready) begin
            if (remaining != 8'd0) begin
              req_addr  <= req_addr + ADDR_W'(ADDR_INC);
              remaining <= remaining - 8'd1;
            end else begin
              req_valid <= 1'b0;
              state     <= ST_FETCH;
            end
          end
        end

        ST_DONE: begin
          if (!run_program) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          req_valid <= 1'b0;
          seq_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vctr_addr_sequencer.sv
// Self-checking bench for vctr_addr_sequencer: vector table, hand-written corner
// sequences, and randomized programs checked against a simple burst model.
module tb_vctr_addr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_program, end_program, abort_program;
  logic        freeze_addr_fifo, send_consec_addr;
  logic [7:0]  consec_count;
  logic [31:0] addr_fifo_dout = '0;
  logic        addr_fifo_empty;
  logic        addr_fifo_rd;
  logic [15:0] words_in_vctr_fifo, vector_fifo_threshold;
  logic [31:0] req_addr;
  logic        req_valid, req_ready;
  logic [2:0]  seq_state;
  logic        seq_busy, seq_done, seq_aborted;
  logic [31:0] issued_cnt;

  int total = 0;
  int bad = 0;

  logic [31:0] fifo_mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  logic [31:0] acc_q[$];
  logic [31:0] exp_q[$];
  int          pop_cnt = 0, valid_cycles = 0, done_cnt = 0;
  int          gate_err = 0, stall_err = 0;
  logic        stall_on = 1'b0;
  logic [31:0] stall_addr = '0;

  typedef struct {
    logic [31:0] word;
    logic        send;
    logic [7:0]  count;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    logic [31:0] exp_beats;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  vctr_addr_sequencer dut (
    .clk(clk), .reset(reset),
    .run_program(run_program), .end_program(end_program), .abort_program(abort_program),
    .freeze_addr_fifo(freeze_addr_fifo), .send_consec_addr(send_consec_addr),
    .consec_count(consec_count), .addr_fifo_dout(addr_fifo_dout),
    .addr_fifo_empty(addr_fifo_empty), .addr_fifo_rd(addr_fifo_rd),
    .words_in_vctr_fifo(words_in_vctr_fifo), .vector_fifo_threshold(vector_fifo_threshold),
    .req_addr(req_addr), .req_valid(req_valid), .req_ready(req_ready),
    .seq_state(seq_state), .seq_busy(seq_busy), .seq_done(seq_done),
    .seq_aborted(seq_aborted), .issued_cnt(issued_cnt)
  );

  // Address FIFO: read data appears one clock after the pop strobe.
  assign addr_fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (addr_fifo_rd && !addr_fifo_empty) begin
      addr_fifo_dout <= fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor: records accepted requests and protocol violations mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (req_valid && req_ready) acc_q.push_back(req_addr);
      if (req_valid) valid_cycles += 1;
      if (addr_fifo_rd) pop_cnt += 1;
      if (seq_done) done_cnt += 1;
      if (addr_fifo_rd && (freeze_addr_fifo || addr_fifo_empty || abort_program ||
                           words_in_vctr_fifo >= vector_fifo_threshold)) gate_err += 1;
      if (stall_on && req_valid && req_addr != stall_addr) stall_err += 1;
      stall_on   = req_valid && !req_ready;
      stall_addr = req_addr;
    end else begin
      stall_on = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total += 1;
    if (act !== exp) begin
      bad += 1;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic run, input logic endp, input logic abrt, input logic rdy);
    run_program   = run;
    end_program   = endp;
    abort_program = abrt;
    req_ready     = rdy;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!seq_done && n < budget);
    checkOutput("done_seen", 32'(seq_done), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_valid && n < budget);
    checkOutput("valid_seen", 32'(req_valid), 32'd1);
  endtask

  function automatic int diff_count(input int base);
    int d;
    d = 0;
    if (acc_q.size() - base != exp_q.size()) d++;
    foreach (exp_q[i]) begin
      if (base + i >= acc_q.size()) d++;
      else if (acc_q[base + i] != exp_q[i]) d++;
    end
    return d;
  endfunction

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_state"},   32'(seq_state),    32'd0);
    checkOutput({tag, "_rd"},      32'(addr_fifo_rd), 32'd0);
    checkOutput({tag, "_valid"},   32'(req_valid),    32'd0);
    checkOutput({tag, "_done"},    32'(seq_done),     32'd0);
    checkOutput({tag, "_aborted"}, 32'(seq_aborted),  32'd0);
    checkOutput({tag, "_busy"},    32'(seq_busy),     32'd0);
    checkOutput({tag, "_addr"},    req_addr,          32'd0);
    checkOutput({tag, "_cnt"},     issued_cnt,        32'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc0, pop0, vc0, rd_at, v_at, c, nw, stable_bad;
    logic        snd, seen;
    logic [7:0]  cnt;
    logic [31:0] w;

    vecs[0] = '{32'h0000_0100, 1'b0, 8'd0,   32'h0000_0100, 32'h0000_0100, 32'd1};
    vecs[1] = '{32'h0000_1000, 1'b1, 8'd3,   32'h0000_1000, 32'h0000_1003, 32'd4};
    vecs[2] = '{32'hFFFF_FFFE, 1'b1, 8'd3,   32'hFFFF_FFFE, 32'h0000_0001, 32'd4};
    vecs[3] = '{32'h0000_0020, 1'b0, 8'd5,   32'h0000_0020, 32'h0000_0020, 32'd1};
    vecs[4] = '{32'h0000_0ABC, 1'b1, 8'd0,   32'h0000_0ABC, 32'h0000_0ABC, 32'd1};
    vecs[5] = '{32'h0000_0010, 1'b1, 8'd255, 32'h0000_0010, 32'h0000_010F, 32'd256};

    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    freeze_addr_fifo = 1'b0; send_consec_addr = 1'b0; consec_count = 8'd0;
    words_in_vctr_fifo = 16'd0; vector_fifo_threshold = 16'd100;
    repeat (3) cyc();
    @(negedge clk);
    check_reset_outputs("reset");
    cyc();
    reset = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].word);
      send_consec_addr = vecs[i].send;
      consec_count     = vecs[i].count;
      acc0 = acc_q.size(); pop0 = pop_cnt; vc0 = valid_cycles;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      rd_at = -100; v_at = -1; c = 0;
      do begin
        @(negedge clk);
        c++;
        if (addr_fifo_rd && rd_at < 0) rd_at = c;
        if (req_valid && v_at < 0) v_at = c;
      end while (!seq_done && c < 600);
      #1;
      checkOutput("tbl_done", 32'(seq_done), 32'd1);
      checkOutput("tbl_cnt", issued_cnt, vecs[i].exp_beats);
      checkOutput("tbl_first", (acc_q.size() > acc0) ? acc_q[acc0] : 32'hDEAD_BEEF, vecs[i].exp_first);
      checkOutput("tbl_last", (acc_q.size() > acc0) ? acc_q[acc_q.size() - 1] : 32'hDEAD_BEEF, vecs[i].exp_last);
      checkOutput("tbl_beats", 32'(acc_q.size() - acc0), vecs[i].exp_beats);
      checkOutput("tbl_valid_cycles", 32'(valid_cycles - vc0), vecs[i].exp_beats);
      checkOutput("tbl_latency", 32'(v_at - rd_at), 32'd2);
      checkOutput("tbl_pops", 32'(pop_cnt - pop0), 32'd1);
      checkOutput("tbl_aborted", 32'(seq_aborted), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      cyc(); cyc();
      @(negedge clk);
      checkOutput("tbl_idle", 32'(seq_state), 32'd0);
      #1;
    end

    $display("[TB] backpressure with wrap");
    w = 32'hFFFF_FFFE;
    push(w);
    send_consec_addr = 1'b1; consec_count = 8'd3;
    exp_q.delete();
    for (int k = 0; k <= 3; k++) exp_q.push_back(w + 32'(k));
    acc0 = acc_q.size();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    wait_valid(20);
    stable_bad = 0;
    repeat (5) begin
      cyc();
      @(negedge clk);
      if (!req_valid || req_addr != 32'hFFFF_FFFE) stable_bad++;
    end
    checkOutput("stall_stable", 32'(stable_bad), 32'd0);
    checkOutput("stall_busy", 32'(seq_busy), 32'd1);
    checkOutput("stall_state", 32'(seq_state), 32'd3);
    cyc();
    req_ready = 1'b1;
    wait_done(40);
    checkOutput("stall_cnt", issued_cnt, 32'd4);
    checkOutput("stall_seq", 32'(diff_count(acc0)), 32'd0);
    cyc();
    run_program = 1'b0;
    cyc(); cyc();

    $display("[TB] throttle and freeze");
    send_consec_addr = 1'b0;
    vector_fifo_threshold = 16'd7500; words_in_vctr_fifo = 16'd7500;
    push(32'h0000_0040);
    pop0 = pop_cnt;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (6) cyc();
    @(negedge clk);
    checkOutput("thr_hold_pops", 32'(pop_cnt - pop0), 32'd0);
    checkOutput("thr_hold_state", 32'(seq_state), 32'd1);
    checkOutput("thr_hold_busy", 32'(seq_busy), 32'd1);
    cyc();
    words_in_vctr_fifo = 16'd7499;
    @(negedge clk);
    checkOutput("thr_release_rd", 32'(addr_fifo_rd), 32'd1);
    wait_done(20);
    checkOutput("thr_done_busy", 32'(seq_busy), 32'd0);
    cyc();
    run_program = 1'b0;
    cyc(); cyc();
    words_in_vctr_fifo = 16'd0;
    freeze_addr_fifo = 1'b1;
    push(32'h0000_0044);
    pop0 = pop_cnt;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (6) cyc();
    @(negedge clk);
    checkOutput("frz_hold_pops", 32'(pop_cnt - pop0), 32'd0);
    cyc();
    freeze_addr_fifo = 1'b0;
    @(negedge clk);
    checkOutput("frz_release_rd", 32'(addr_fifo_rd), 32'd1);
    wait_done(20);
    checkOutput("frz_state", 32'(seq_state), 32'd4);
    cyc();
    run_program = 1'b0;
    cyc(); cyc();

    $display("[TB] abort mid-burst, restart");
    push(32'h0000_2000); push(32'h0000_3000);
    send_consec_addr = 1'b1; consec_count = 8'd3;
    pop0 = pop_cnt;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    wait_valid(20);
    cyc();
    req_ready = 1'b1;
    cyc();
    req_ready = 1'b0;
    abort_program = 1'b1;
    cyc();
    @(negedge clk);
    checkOutput("abort_valid", 32'(req_valid), 32'd0);
    checkOutput("abort_done", 32'(seq_done), 32'd1);
    checkOutput("abort_sticky", 32'(seq_aborted), 32'd1);
    checkOutput("abort_state", 32'(seq_state), 32'd4);
    checkOutput("abort_cnt", issued_cnt, 32'd1);
    repeat (4) cyc();
    @(negedge clk);
    checkOutput("abort_pops", 32'(pop_cnt - pop0), 32'd1);
    checkOutput("abort_fifo_left", 32'(wr_ptr - rd_ptr), 32'd1);
    checkOutput("abort_done_pulse", 32'(seq_done), 32'd0);
    cyc();
    abort_program = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    checkOutput("done_hold", 32'(seq_state), 32'd4);
    cyc();
    run_program = 1'b0;
    cyc();
    @(negedge clk);
    checkOutput("done_to_idle", 32'(seq_state), 32'd0);
    cyc();
    send_consec_addr = 1'b0;
    acc0 = acc_q.size();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    cyc();
    @(negedge clk);
    checkOutput("restart_state", 32'(seq_state), 32'd1);
    checkOutput("restart_cnt_clr", issued_cnt, 32'd0);
    checkOutput("restart_abort_clr", 32'(seq_aborted), 32'd0);
    wait_done(20);
    checkOutput("restart_cnt", issued_cnt, 32'd1);
    checkOutput("restart_addr", (acc_q.size() > acc0) ? acc_q[acc0] : 32'hDEAD_BEEF, 32'h0000_3000);

    $display("[TB] reset mid-burst");
    cyc();
    run_program = 1'b0;
    cyc(); cyc();
    push(32'h0000_5000);
    send_consec_addr = 1'b1; consec_count = 8'd5;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    wait_valid(20);
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    @(negedge clk);
    check_reset_outputs("midreset");
    cyc();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    cyc();

    $display("[TB] randomized programs");
    vector_fifo_threshold = 16'd100;
    for (int r = 0; r < 6; r++) begin
      cyc();
      run_program = 1'b0;
      cyc(); cyc();
      nw  = $urandom_range(1, 6);
      snd = 1'($urandom_range(0, 1));
      cnt = 8'($urandom_range(0, 4));
      exp_q.delete();
      for (int i = 0; i < nw; i++) begin
        w = (r % 2 == 1) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
        push(w);
        for (int k = 0; k <= (snd ? int'(cnt) : 0); k++) exp_q.push_back(w + 32'(k));
      end
      send_consec_addr = snd;
      consec_count     = cnt;
      acc0 = acc_q.size(); pop0 = pop_cnt;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      seen = 1'b0; c = 0;
      while (c < 3000 && !seen) begin
        cyc();
        req_ready          = ($urandom_range(0, 3) != 0);
        freeze_addr_fifo   = ($urandom_range(0, 4) == 0);
        words_in_vctr_fifo = 16'($urandom_range(80, 105));
        @(negedge clk);
        if (seq_done) seen = 1'b1;
        c++;
      end
      #1;
      checkOutput("rnd_done", 32'(seen), 32'd1);
      checkOutput("rnd_cnt", issued_cnt, 32'(exp_q.size()));
      checkOutput("rnd_seq", 32'(diff_count(acc0)), 32'd0);
      checkOutput("rnd_pops", 32'(pop_cnt - pop0), 32'(nw));
      checkOutput("rnd_aborted", 32'(seq_aborted), 32'd0);
      freeze_addr_fifo = 1'b0;
      words_in_vctr_fifo = 16'd0;
    end

    checkOutput("gate_violations", 32'(gate_err), 32'd0);
    checkOutput("stall_violations", 32'(stall_err), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
